// File: rtl/core_pkg.sv
// Shared definitions for the fetch stage and its decoder: the opcode constants, the reset PC default
// and the fetch FSM state type.
package core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection for the fetch stage.
// Priority: jump first, then a taken branch, then the fall-through address.
module next_pc_logic
  import core_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_pc,
  input  logic [25:0]       i_ir_target,
  input  logic [DATA_W-1:0] i_sign_imm,
  input  logic              i_branch,
  input  logic              i_jump,
  input  logic              i_zero,
  output logic [DATA_W-1:0] o_pc_plus4,
  output logic [DATA_W-1:0] o_pc_next
);

  logic [DATA_W-1:0] w_pc_plus4;
  logic [DATA_W-1:0] w_branch_tgt;
  logic [DATA_W-1:0] w_jump_tgt;

  assign w_pc_plus4   = i_pc + DATA_W'(4);
  assign w_branch_tgt = w_pc_plus4 + (i_sign_imm << 2);
  assign w_jump_tgt   = {w_pc_plus4[DATA_W-1:DATA_W-4], i_ir_target, 2'b00};
  assign o_pc_plus4   = w_pc_plus4;

  // The decoder leaves Branch undefined on jumps, so Jump has to be checked before Branch is looked at.
  always_comb begin
    o_pc_next = w_pc_plus4;
    if (i_jump) begin
      o_pc_next = w_jump_tgt;
    end else if (i_branch && i_zero) begin
      o_pc_next = w_branch_tgt;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and the IR, and fetches from imem over a req/ack handshake.
// With FETCH_INSTR_COUNT_EN defined, instr_count counts retired instructions; otherwise it is tied to 0.
//
// state | meaning
// IDLE  | out of reset, nothing requested
// REQ   | first request cycle; an ack here is a zero-wait fetch
// WAIT  | request held until imem acks
// HOLD  | IR valid, waiting for the core to retire it
module fetch_unit
  import core_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pc_plus4,
  input  logic              instr_retire,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              Zero,
  input  logic [DATA_W-1:0] SignImm,
  output logic [31:0]       instr_count
);

  fetch_state_e      r_state;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic              r_req;
  logic              r_valid;
  logic [DATA_W-1:0] w_pc_next;
  logic [DATA_W-1:0] w_pc_plus4;
  logic              w_retire_ok;

  next_pc_logic #(.DATA_W(DATA_W)) u_next_pc (
    .i_pc        (r_pc),
    .i_ir_target (r_ir[25:0]),
    .i_sign_imm  (SignImm),
    .i_branch    (Branch),
    .i_jump      (Jump),
    .i_zero      (Zero),
    .o_pc_plus4  (w_pc_plus4),
    .o_pc_next   (w_pc_next)
  );

  // Only a retire seen while the IR is held counts; retires in any other state are dropped.
  assign w_retire_ok = (r_state == ST_HOLD) && instr_retire;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_REQ;
          r_req   <= 1'b1;
        end
        ST_REQ, ST_WAIT: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_state <= ST_HOLD;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (instr_retire) begin
            r_pc    <= w_pc_next;
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_INSTR_COUNT_EN
  logic [31:0] r_instr_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_instr_count <= '0;
    end else if (w_retire_ok) begin
      r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign instr_count = r_instr_count;
`else
  logic w_unused_retire_ok;
  assign w_unused_retire_ok = w_retire_ok;
  assign instr_count        = '0;
`endif

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instr       = r_ir;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized fetch/retire traffic,
// checked against a PC/IR/count reference model.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_retire;
  logic        Branch;
  logic        Jump;
  logic        Zero;
  logic [31:0] SignImm;
  logic [31:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_cnt;

  fetch_unit #(.DATA_W(32), .RESET_PC(32'h0000_0000)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr_retire (instr_retire),
    .Branch       (Branch),
    .Jump         (Jump),
    .Zero         (Zero),
    .SignImm      (SignImm),
    .instr_count  (instr_count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef FETCH_INSTR_COUNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] ir,
                                             input bit br, input bit j, input bit z,
                                             input logic [31:0] simm);
    logic [31:0] seq;
    seq = cur_pc + 32'd4;
    if (j) return {seq[31:28], ir[25:0], 2'b00};
    if (br && z) return seq + simm * 32'd4;
    return seq;
  endfunction

  // Starts in REQ. Holds ack low for 'waits' cycles and then acks with 'data'.
  task automatic fetch(input logic [31:0] data, input int waits, input bit spurious);
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0; instr_retire = spurious; imem_rdata = $urandom;
      tick();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0 || instr !== m_ir ||
          pc !== m_pc || instr_count !== exp_cnt()) begin
        n_fail++;
        $display("FAIL fetch_wait: req=%b addr=%h valid=%b ir=%h cnt=%0d, expected req=1 addr=%h valid=0 ir=%h cnt=%0d",
                 imem_req, imem_addr, instr_valid, instr, instr_count, m_pc, m_ir, exp_cnt());
      end
    end
    imem_ack = 1'b1; imem_rdata = data; instr_retire = spurious;
    tick();
    imem_ack = 1'b0; instr_retire = 1'b0;
    m_ir = data;
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr !== m_ir || pc !== m_pc ||
        imem_addr !== m_pc || pc_plus4 !== m_pc + 32'd4 || instr_count !== exp_cnt()) begin
      n_fail++;
      $display("FAIL fetch_ack: req=%b valid=%b ir=%h pc=%h p4=%h cnt=%0d, expected req=0 valid=1 ir=%h pc=%h p4=%h cnt=%0d",
               imem_req, instr_valid, instr, pc, pc_plus4, instr_count, m_ir, m_pc, m_pc + 32'd4, exp_cnt());
    end
  endtask

  // Starts in HOLD. Keeps the IR for 'holds' cycles and then retires with the given next-PC inputs.
  task automatic retire(input bit br, input bit j, input bit z, input logic [31:0] simm, input int holds);
    Branch = br; Jump = j; Zero = z; SignImm = simm;
    for (int i = 0; i < holds; i++) begin
      instr_retire = 1'b0;
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== m_ir || pc !== m_pc) begin
        n_fail++;
        $display("FAIL hold_stable: valid=%b req=%b ir=%h pc=%h, expected valid=1 req=0 ir=%h pc=%h",
                 instr_valid, imem_req, instr, pc, m_ir, m_pc);
      end
    end
    instr_retire = 1'b1;
    tick();
    instr_retire = 1'b0;
    m_pc  = model_next(m_pc, m_ir, br, j, z, simm);
    m_cnt = m_cnt + 32'd1;
    n_checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== m_pc || pc !== m_pc ||
        pc_plus4 !== m_pc + 32'd4 || instr_count !== exp_cnt()) begin
      n_fail++;
      $display("FAIL retire: req=%b valid=%b addr=%h pc=%h p4=%h cnt=%0d, expected req=1 valid=0 addr=%h pc=%h p4=%h cnt=%0d",
               imem_req, instr_valid, imem_addr, pc, pc_plus4, instr_count, m_pc, m_pc, m_pc + 32'd4, exp_cnt());
    end
  endtask

  task automatic check_pc(input string name, input logic [31:0] want);
    n_checks++;
    if (pc !== want || imem_addr !== want) begin
      n_fail++;
      $display("FAIL %s: pc=%h addr=%h, expected %h", name, pc, imem_addr, want);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; instr_retire = 1'b1;
    Branch = 1'b0; Jump = 1'b0; Zero = 1'b0; SignImm = '0;
    tick(); tick();
    m_pc = 32'h0; m_ir = 32'h0; m_cnt = 32'h0;
    n_checks++;
    if (pc !== 32'h0 || instr !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
        instr_count !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: pc=%h ir=%h req=%b valid=%b cnt=%0d, expected 0", pc, instr,
               imem_req, instr_valid, instr_count);
    end
    RST = 1'b0; instr_retire = 1'b0;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h0 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_to_req: req=%b valid=%b ir=%h addr=%h, expected req=1 valid=0 ir=0 addr=0",
               imem_req, instr_valid, instr, imem_addr);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      check_pc("seq_addr", 32'(i * 4));
      fetch($urandom, 0, 1'b0);
      retire(1'b0, 1'b0, 1'b0, $urandom, 0);
    end
  endtask

  task automatic test_wait();
    check_pc("wait_start_addr", 32'h10);
    fetch(32'h2001_0005, 3, 1'b1);
    retire(1'b0, 1'b0, 1'b1, 32'h0000_0007, 2);
  endtask

  task automatic test_branch();
    fetch(32'h0800_0008, 0, 1'b0);
    retire(1'b0, 1'b1, 1'b0, $urandom, 0);
    check_pc("jump_to_20", 32'h20);
    fetch(32'h1000_FFFE, 1, 1'b0);
    retire(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 0);
    check_pc("beq_taken", 32'h1C);
    fetch($urandom, 0, 1'b0);
    retire(1'b0, 1'b0, 1'b0, 32'h0, 0);
    fetch(32'h1000_FFFE, 0, 1'b0);
    retire(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 0);
    check_pc("beq_not_taken", 32'h24);
  endtask

  task automatic test_jump();
    fetch($urandom, 0, 1'b0);
    retire(1'b1, 1'b0, 1'b1, (32'h3000_0040 - (m_pc + 32'd4)) >> 2, 0);
    check_pc("reach_3000_0040", 32'h3000_0040);
    fetch(32'h0800_0100, 0, 1'b0);
    retire(1'($urandom), 1'b1, 1'($urandom), $urandom, 1);
    check_pc("jump_target", 32'h3000_0400);
  endtask

  task automatic test_wrap();
    fetch($urandom, 0, 1'b0);
    retire(1'b1, 1'b0, 1'b1, (32'hFFFF_FFFC - (m_pc + 32'd4)) >> 2, 0);
    check_pc("reach_top", 32'hFFFF_FFFC);
    fetch($urandom, 2, 1'b0);
    retire(1'b0, 1'b0, 1'b0, 32'h0, 0);
    check_pc("wrap_to_zero", 32'h0);
  endtask

  task automatic test_random();
    logic [15:0] imm;
    for (int i = 0; i < 40; i++) begin
      imm = 16'($urandom);
      fetch($urandom, int'($urandom_range(0, 3)), 1'($urandom));
      retire(1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), {{16{imm[15]}}, imm},
             int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_reset_mid_wait();
    imem_ack = 1'b0;
    tick();
    RST = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick();
    m_pc = 32'h0; m_ir = 32'h0; m_cnt = 32'h0;
    n_checks++;
    if (pc !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0 ||
        instr_count !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: pc=%h ir=%h valid=%b req=%b cnt=%0d, expected 0",
               pc, instr, instr_valid, imem_req, instr_count);
    end
    RST = 1'b0; imem_ack = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || instr !== 32'h0 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_wait_restart: req=%b ir=%h addr=%h, expected req=1 ir=0 addr=0",
               imem_req, instr, imem_addr);
    end
  endtask

  task automatic test_count();
    logic [31:0] want;
    for (int i = 0; i < 5; i++) begin
      fetch($urandom, (i == 0) ? 1 : 0, (i == 0));
      retire(1'b0, 1'b0, 1'b0, 32'h0, 0);
    end
`ifdef FETCH_INSTR_COUNT_EN
    want = 32'd5;
`else
    want = 32'd0;
`endif
    n_checks++;
    if (instr_count !== want) begin
      n_fail++;
      $display("FAIL instr_count: got %0d, expected %0d", instr_count, want);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait();
    test_branch();
    test_jump();
    test_wrap();
    test_random();
    test_reset_mid_wait();
    test_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the main opcode decoder.
- Holds the PC and fetches from instruction memory over a req/ack handshake.
- Presents the instruction word to decode; instr[31:26] feeds the decoder opcode input.
- Computes the next PC from the decoder's Branch/Jump, the ALU Zero flag and the sign-extended immediate, then advances when the core retires the instruction.

Parameters:
- DATA_W, 32, width of PC and instruction word (only 32 is supported).
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  DATA_W  fetch address; equals PC.
- imem_ack  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  DATA_W  instruction word from memory.
- instr  output  DATA_W  held instruction register (IR).
- instr_valid  output  1  IR holds a fetched, unretired instruction.
- pc  output  DATA_W  address of instr.
- pc_plus4  output  DATA_W  pc + 4, for link/debug.
- instr_retire  input  1  core has completed instr this cycle; next-PC inputs are valid.
- Branch  input  1  from decoder.
- Jump  input  1  from decoder.
- Zero  input  1  from ALU.
- SignImm  input  DATA_W  sign-extended instr[15:0].
- instr_count  output  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset: RST sampled at the clock edge. Next state is IDLE.
- Reset values: PC=RESET_PC, IR=0, imem_req=0, instr_valid=0, instr_count=0.
- Reset wins over every other event, including imem_ack or instr_retire in the same cycle.
- An ack arriving while in IDLE, or in the cycle RST is asserted, is ignored.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: outputs idle. Next state is REQ one cycle after RST deasserts.
- REQ: imem_req=1, imem_addr=PC.
  - imem_ack=1: IR<=imem_rdata, go to HOLD (zero-wait fetch).
  - imem_ack=0: go to WAIT.
- WAIT: imem_req held at 1; imem_addr stable at PC. On imem_ack: IR<=imem_rdata, go to HOLD. Stays in WAIT indefinitely without ack.
- HOLD: instr_valid=1, imem_req=0. IR and PC are stable until instr_retire.
  - instr_retire=1: PC<=PCNext, go to REQ.
  - instr_retire is ignored in every state except HOLD.
- Minimum fetch-to-fetch time is 2 cycles: REQ with ack, then HOLD with retire.
- Next-PC priority (highest first):
  - Jump=1: PCNext={pc_plus4[31:28], IR[25:0], 2'b00}. Branch and Zero are don't-care, since the decoder drives Branch=x for jumps.
  - Branch=1 and Zero=1: PCNext=pc_plus4+(SignImm<<2).
  - Otherwise: PCNext=pc_plus4.
- Arithmetic: all adds are modulo 2^32; wrap past 32'hFFFF_FFFC goes to 0 with no flag. PC[1:0] is always 2'b00 by construction.
- Back-to-back retire: a retire in HOLD followed by an immediate ack in REQ yields a new instruction every 2 cycles.
- No instruction is ever dropped or fetched twice unless reset intervenes.

Optional Feature:
- Macro: FETCH_INSTR_COUNT_EN.
- Defined: 32-bit counter increments on each accepted instr_retire in HOLD. It wraps from FFFF_FFFF to 0, is reset to 0, and drives instr_count.
- Undefined: no counter logic; instr_count is tied to 0. The port list is identical in both builds.

Decomposition:
- Shared package (core_pkg): OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_ADDI=6'b001000, OP_J=6'b000010; RESET_PC default; fetch-state enum type.
- One sub-module, next_pc_logic: combinational PCNext from pc, IR[25:0], SignImm, Branch, Jump, Zero.
- FSM, IR, PC and counter live in fetch_unit.

Test Plan:
- Reset then zero-wait memory (ack in REQ), retire each HOLD, no branches -> imem_addr sequence 0,4,8,C; instr_valid high every 2nd cycle.
- WAIT path: ack delayed 3 cycles at PC=0x10 -> imem_req high 4 cycles with imem_addr=0x10 stable; IR captured only on the ack cycle.
- BEQ taken: PC=0x20, Branch=1, Zero=1, SignImm=0xFFFF_FFFE -> next PC=0x1C. Same with Zero=0 -> next PC=0x24.
- Jump: PC=0x3000_0040, IR=0x0800_0100, Jump=1, Branch=x -> next PC=0x3000_0400.
- Reset mid-WAIT with imem_ack=1 in the same cycle -> PC=RESET_PC, instr_valid=0, IR=0, state IDLE; the ack is discarded.
- FETCH_INSTR_COUNT_EN defined: 5 retires, plus one spurious retire in REQ -> instr_count=5. Undefined -> instr_count stays 0.
